// File: rtl/pt2262_tx_seq.sv
// PT2262-style frame sequencer: serialises 8 address trits, 4 data trits and a
// sync gap as pulse-width-coded sub-bits, repeated FRAMES times per start.
module pt2262_tx_seq #(
    parameter int ALPHA_CYC = 100,
    parameter int FRAMES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ax,
    input  logic [3:0]  d,
    output logic        dout,
    output logic        busy,
    output logic        done
);
    localparam int PW = (ALPHA_CYC > 1) ? $clog2(ALPHA_CYC) : 1;
    localparam int FW = $clog2(FRAMES + 1);

    typedef enum logic [2:0] {IDLE, BIT_H, BIT_L, SYNC_H, SYNC_L} state_t;

    state_t          r_state, w_nxt;
    logic [PW-1:0]   r_pre;
    logic [6:0]      r_ph;
    logic [4:0]      r_idx;
    logic [FW-1:0]   r_frm;
    logic [15:0]     r_ax;
    logic [3:0]      r_d;
    logic            r_dout, r_busy, r_done;
    logic            w_tick, w_sub, w_last, w_end;
    logic [6:0]      w_lim;

    assign w_tick = (r_pre == PW'(ALPHA_CYC - 1));
    assign w_last = (r_frm == FW'(FRAMES - 1));
    // Address sub-bits go out high bit of each pair first; data bits are doubled.
    assign w_sub  = r_idx[4] ? r_d[r_idx[2:1]] : r_ax[r_idx[3:0] ^ 4'd1];

    always_comb begin
        w_nxt = r_state;
        w_lim = 7'd3;
        w_end = 1'b0;
        case (r_state)
            BIT_H:   w_lim = w_sub ? 7'd11 : 7'd3;
            BIT_L:   w_lim = w_sub ? 7'd3  : 7'd11;
            SYNC_H:  w_lim = 7'd3;
            SYNC_L:  w_lim = 7'd123;
            default: w_lim = 7'd3;
        endcase
        w_end = w_tick && (r_ph == w_lim);
        case (r_state)
            IDLE:    if (start) w_nxt = BIT_H;
            BIT_H:   if (w_end) w_nxt = BIT_L;
            BIT_L:   if (w_end) w_nxt = (r_idx == 5'd23) ? SYNC_H : BIT_H;
            SYNC_H:  if (w_end) w_nxt = SYNC_L;
            SYNC_L:  if (w_end) w_nxt = w_last ? IDLE : BIT_H;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_ph   <= '0;
            r_idx  <= '0;
            r_frm  <= '0;
            r_ax   <= '0;
            r_d    <= '0;
            r_dout <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_pre <= '0;
                r_ph  <= '0;
                if (start) begin
                    r_ax  <= ax;
                    r_d   <= d;
                    r_idx <= '0;
                    r_frm <= '0;
                end
            end else begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_end)       r_ph <= '0;
                else if (w_tick) r_ph <= r_ph + 7'd1;
                if (r_state == BIT_L && w_end)
                    r_idx <= (r_idx == 5'd23) ? 5'd0 : r_idx + 5'd1;
                if (r_state == SYNC_L && w_end && !w_last)
                    r_frm <= r_frm + FW'(1);
            end
            // Outputs track the next state so they line up with the state register.
            r_dout <= (w_nxt == BIT_H) || (w_nxt == SYNC_H);
            r_busy <= (w_nxt != IDLE);
            r_done <= (r_state == SYNC_L) && w_end && w_last;
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_pt2262_tx_seq.sv
// Directed bench for pt2262_tx_seq: one single-frame and one four-frame instance,
// both at two cycles per alpha, with hand-computed waveform windows.
module tb_pt2262_tx_seq;
    localparam int A = 2;
    localparam logic [31:0] W0 = 32'hFF00_0000;  // 8 high, 24 low
    localparam logic [31:0] W1 = 32'hFFFF_FF00;  // 24 high, 8 low

    logic        clk = 1'b0;
    logic        rst, start1, start4;
    logic [15:0] ax;
    logic [3:0]  d;
    logic        dout1, busy1, done1, dout4, busy4, done4;
    int          errs = 0;
    int          nchk = 0;
    logic        wav[$];
    int          bcyc, dcnt;

    always #5 clk = ~clk;

    pt2262_tx_seq #(.ALPHA_CYC(A), .FRAMES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .ax(ax), .d(d),
        .dout(dout1), .busy(busy1), .done(done1));

    pt2262_tx_seq #(.ALPHA_CYC(A), .FRAMES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .ax(ax), .d(d),
        .dout(dout4), .busy(busy4), .done(done4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Records dout for every busy cycle; returns in the done cycle.
    task automatic capture(input bit sel, input int maxc);
        logic b, o, dn;
        bcyc = 0; dcnt = 0; wav.delete();
        for (int c = 0; c < maxc; c++) begin
            b  = sel ? busy4 : busy1;
            o  = sel ? dout4 : dout1;
            dn = sel ? done4 : done1;
            if (b) begin bcyc++; wav.push_back(o); end
            if (dn) begin dcnt++; return; end
            @(negedge clk);
        end
        chk("capture timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] win(input int base);
        logic [31:0] v = '0;
        for (int j = 0; j < 32; j++) v[31-j] = wav[base+j];
        return v;
    endfunction

    function automatic logic [23:0] model_bits(input logic [15:0] a, input logic [3:0] dd);
        logic [23:0] b = '0;
        for (int k = 0; k < 8; k++) begin
            case (a[2*k +: 2])
                2'b00:   begin b[2*k] = 1'b0; b[2*k+1] = 1'b0; end
                2'b11:   begin b[2*k] = 1'b1; b[2*k+1] = 1'b1; end
                2'b01:   begin b[2*k] = 1'b0; b[2*k+1] = 1'b1; end
                default: begin b[2*k] = 1'b1; b[2*k+1] = 1'b0; end
            endcase
        end
        for (int j = 0; j < 4; j++) begin
            b[16+2*j] = dd[j];
            b[17+2*j] = dd[j];
        end
        return b;
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [23:0] bits);
        int ones = 0;
        if (wav.size() < base + 512*A) begin
            chk({tag, " length"}, wav.size(), base + 512*A);
            return;
        end
        for (int i = 0; i < 24; i++)
            chk($sformatf("%s sb%0d", tag, i), win(base + 32*i), bits[i] ? W1 : W0);
        chk({tag, " sync head"}, win(base + 768), W0);
        for (int j = 0; j < 256; j++) if (wav[base+768+j]) ones++;
        chk({tag, " sync high"}, ones, 8);
    endtask

    task automatic pulse(input bit sel);
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
    endtask

    initial begin
        int bad;
        int exp_t[12] = '{2, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        logic s0, s1;
        int t;
        logic [23:0] orig;

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; ax = '0; d = '0;
        repeat (3) @(negedge clk);
        chk("reset outs", {dout1, busy1, done1, dout4, busy4, done4}, 6'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle outs", {dout1, busy1, done1}, 3'b0);

        // all-zero word
        ax = 16'h0000; d = 4'h0;
        pulse(0);
        chk("zero first", {dout1, busy1}, 2'b11);
        capture(0, 2000);
        chk("zero busy", bcyc, 1024);
        chk("zero done", dcnt, 1);
        chk("zero done outs", {dout1, busy1}, 2'b00);
        check_frame("zero", 0, model_bits(16'h0000, 4'h0));
        @(negedge clk);
        chk("zero done width", done1, 1'b0);

        // all-F address, all-one data
        ax = 16'h5555; d = 4'hF;
        pulse(0);
        capture(0, 2000);
        chk("allf busy", bcyc, 1024);
        check_frame("allf", 0, model_bits(16'h5555, 4'hF));

        // mixed word, decoded back to trits
        repeat (2) @(negedge clk);
        ax = 16'hC301; d = 4'b1010;
        pulse(0);
        capture(0, 2000);
        chk("mixed busy", bcyc, 1024);
        if (wav.size() >= 1024) begin
            for (int k = 0; k < 12; k++) begin
                s0 = (win(64*k) == W1);
                s1 = (win(64*k + 32) == W1);
                t = (s0 && s1) ? 1 : (!s0 && !s1) ? 0 : (!s0 && s1) ? 2 : 3;
                chk($sformatf("mixed trit%0d", k), t, exp_t[k]);
            end
        end

        // back-to-back: start in the done cycle
        ax = 16'h00FF; d = 4'h3;
        pulse(0);
        chk("b2b start", {dout1, busy1}, 2'b11);
        capture(0, 2000);
        chk("b2b busy", bcyc, 1024);
        check_frame("b2b", 0, model_bits(16'h00FF, 4'h3));

        // reset mid-stream held 3 cycles
        repeat (3) @(negedge clk);
        pulse(0);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst outs", {dout1, busy1, done1}, 3'b0);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({dout1, busy1, done1} != 3'b0) bad++;
        end
        chk("midrst stay0", bad, 0);

        // four frames, inputs changed and start re-pulsed while busy
        ax = 16'hC301; d = 4'b1010;
        orig = model_bits(16'hC301, 4'b1010);
        pulse(1);
        fork
            capture(1, 6000);
            begin
                repeat (300) @(negedge clk);
                ax = 16'hFFFF; d = 4'h0;
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
            end
        join
        chk("rep busy", bcyc, 4096);
        chk("rep done", dcnt, 1);
        for (int f = 0; f < 4; f++) check_frame($sformatf("rep f%0d", f), 1024*f, orig);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy4 || done4) bad++;
        end
        chk("rep no requeue", bad, 0);

        // reset during SYNC_L of the second frame
        pulse(1);
        repeat (1849) @(negedge clk);
        chk("syncl pos", {dout4, busy4}, 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("syncl rst outs", {dout4, busy4, done4}, 3'b0);
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (busy4 || done4) bad++;
        end
        chk("syncl no done", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/pt2262_tx_seq.md
# pt2262_tx_seq

Frame sequencer for the PT2262-compatible encoder. It latches the 16-bit tri-state address code word `ax` from the address-code generator and a 4-bit data nibble. It then serialises them as PT2262 pulse-width-coded words (8 address trits, 4 data trits, sync), repeated a fixed number of times, on the single-bit `dout` line that drives the RF/IR modulator. Start and status are via a start/busy/done handshake.

## Interface

Parameters:
- `ALPHA_CYC`, default 100: clock cycles per α, the oscillator base period. Minimum 1.
- `FRAMES`, default 4: words sent per start. Minimum 1.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `ax`  input  16  address code word. Pair `ax[2k+1:2k]` is trit Ak: 00 = bit 0, 11 = bit 1, 01 = F.
- `d`  input  4  data bits D0..D3 = `d[0]`..`d[3]`.
- `dout`  output  1  encoded serial waveform, registered.
- `busy`  output  1  high from accept until transmission ends.
- `done`  output  1  one-cycle pulse at end of transmission.

## Operation

- **Sub-bit encoding.** Each sub-bit lasts 16α.
  - Value 0: high 4α, then low 12α.
  - Value 1: high 12α, then low 4α.
- **Frame content.** 24 sub-bits, then sync.
  - Trits A0..A7: sub-bits `ax[2k+1]` then `ax[2k]`. 01 therefore gives 0,1, which is the PT2262 F pattern.
  - Trits D0..D3: `d[j]` sent twice (00 or 11).
  - Sync: high 4α, low 124α.
- **Frame length.** 24×16α + 128α = 512α = 512·`ALPHA_CYC` cycles.
- **FSM states:** IDLE, BIT_H, BIT_L, SYNC_H, SYNC_L.
  - IDLE, `start`=1: latch `ax`/`d` into a shadow register, clear sub-bit index and frame counter, go to BIT_H.
  - BIT_H → BIT_L after 4α (bit 0) or 12α (bit 1).
  - BIT_L → BIT_H after the remainder of 16α if index < 23 (index increments). Otherwise → SYNC_H.
  - SYNC_H → SYNC_L after 4α.
  - SYNC_L → after 124α:
    - if frame counter < `FRAMES`−1: increment the counter and go to BIT_H, index 0;
    - otherwise go to IDLE.
- **Counters.**
  - α prescaler: 0..`ALPHA_CYC`−1.
  - α phase counter: 7 bits, covers 124.
  - Sub-bit index: 5 bits.
  - Frame counter: `$clog2(FRAMES+1)` bits.
  - Shadow register is stable for the whole transmission. Input changes while busy have no effect.
- `dout` = 1 in BIT_H/SYNC_H, 0 otherwise.

## Timing

- **Reset values:** `dout`=0, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- **Reset mid-operation:** next cycle is IDLE with all outputs 0. No `done` pulse. The word is aborted.
- **Accept.** `start` is sampled high at edge k in IDLE.
  - From cycle k+1: `busy`=1 and `dout`=1 (first BIT_H cycle).
  - Waveform edges fall on exact multiples of `ALPHA_CYC` relative to cycle k+1.
- **End of transmission.** After FRAMES·512·`ALPHA_CYC` busy cycles, the FSM enters IDLE.
  - In that first IDLE cycle: `done`=1, `busy`=0, `dout`=0.
  - `done` lasts exactly one cycle.
- **Back-to-back.** `start` high in the `done` cycle is accepted. The next word's `dout` rise follows with no gap beyond that one cycle.
- `start` while busy is ignored, not queued.
- `ALPHA_CYC`=1 is legal: the prescaler is constant 0 and one α = one cycle.

## Test plan

- **Reset.** Hold `rst` 3 cycles mid-stream, release → `dout`/`busy`/`done` are 0 and stay 0 with `start`=0.
- **All-zero word.** `ALPHA_CYC`=2, `FRAMES`=1, `ax`=16'h0000, `d`=4'h0, start pulse →
  - 24 periods of 8 high / 24 low;
  - then 8 high / 248 low;
  - `busy` high exactly 1024 cycles;
  - `done` pulse at cycle 1025 after accept.
- **All-F plus ones.** `ax`=16'h5555, `d`=4'hF →
  - first 16 sub-bits alternate 8H/24L then 24H/8L;
  - last 8 sub-bits all 24H/8L;
  - sync unchanged.
- **Mixed word.** `ax`=16'hC301 (A0=F, A1=0, A4=1, A5=0, A7=1), `d`=4'b1010 → the decoded trit sequence in the monitor equals F,0,0,0,1,0,0,1,0,1,0,1.
- **Repeat and input isolation.** `FRAMES`=4. Change `ax` and pulse `start` during `busy` →
  - 4 identical words with the original code;
  - `busy` = 4096 cycles (`ALPHA_CYC`=2);
  - a single `done`.
- **Edge cases.**
  - Reset asserted in SYNC_L of frame 2 → IDLE next cycle, no `done`.
  - `start` in the `done` cycle → new transmission begins, `dout` high next cycle.
